// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: rate-1/2, K=3 convolutional encoder, transmit side.
// Accepts a parallel message word plus a starting trellis state. It then
// streams one 2-bit coded symbol per valid/ready handshake, MSB of the
// message first. Two zero tail symbols follow and flush the trellis to 00.
//
// Ports:
//   clk, reset    - single rising-edge clock, synchronous active-high reset
//   start         - frame request, honoured only while busy=0
//   msg           - message bits, captured on accept
//   init_state    - starting encoder state {s1,s0}, captured on accept
//   tx_ready      - downstream accepts tx_data this cycle
//   tx_valid      - tx_data holds a valid coded symbol
//   tx_data       - coded symbol {G0 parity, G1 parity}
//   tx_last       - marks the final tail symbol
//   busy          - frame in progress
//   done          - one-cycle pulse after the final symbol handshake
//   end_state     - encoder state after the last symbol
module conv_encoder_tx #(
  parameter int unsigned     data_width = 2,
  parameter int unsigned     seq_width  = 5,
  parameter logic [2:0]      G0         = 3'b111,
  parameter logic [2:0]      G1         = 3'b101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [seq_width-1:0]  msg,
  input  logic [data_width-1:0] init_state,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [data_width-1:0] tx_data,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] end_state
);

  localparam int unsigned CW = (seq_width > 1) ? $clog2(seq_width) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [seq_width-1:0]  sr_q, sr_d;
  logic [data_width-1:0] state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [data_width-1:0] tx_data_q, tx_data_d;
  logic                  tx_last_q, tx_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [data_width-1:0] end_state_q, end_state_d;
  logic                  xfer;

  function automatic logic [1:0] encode(input logic u, input logic [1:0] s);
    logic [2:0] reg3;
    reg3 = {u, s};
    return {^(reg3 & G0), ^(reg3 & G1)};
  endfunction

  assign xfer = tx_valid_q && tx_ready;

  // state_q and sr_q[MSB] always describe the symbol currently on tx_data.
  // A transfer therefore advances the trellis first (state_d) and then
  // encodes the following symbol from the advanced state.
  always_comb begin
    fsm_d       = fsm_q;
    sr_d        = sr_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    tx_last_d   = tx_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    end_state_d = end_state_q;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          sr_d       = msg;
          state_d    = init_state;
          tx_data_d  = encode(msg[seq_width-1], init_state);
          tx_valid_d = 1'b1;
          tx_last_d  = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          fsm_d      = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          state_d = {sr_q[seq_width-1], state_q[1]};
          sr_d    = {sr_q[seq_width-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(seq_width - 1)) begin
            tx_data_d = encode(1'b0, state_d);
            fsm_d     = TAIL;
          end else begin
            tx_data_d = encode(sr_d[seq_width-1], state_d);
          end
        end
      end
      TAIL: begin
        if (xfer) begin
          state_d = {1'b0, state_q[1]};
          if (tx_last_q) begin
            tx_valid_d  = 1'b0;
            tx_last_d   = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            end_state_d = state_d;
            fsm_d       = IDLE;
          end else begin
            tx_data_d = encode(1'b0, state_d);
            tx_last_d = 1'b1;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      sr_q        <= '0;
      state_q     <= '0;
      cnt_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      end_state_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      sr_q        <= sr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_last_q   <= tx_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      end_state_q <= end_state_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_last   = tx_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign end_state = end_state_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed bench for conv_encoder_tx (data_width=2, seq_width=5).
module tb_conv_encoder_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] msg;
  logic [1:0] init_state;
  logic       tx_ready;
  logic       tx_valid;
  logic [1:0] tx_data;
  logic       tx_last;
  logic       busy;
  logic       done;
  logic [1:0] end_state;

  int unsigned vectors;
  int unsigned miscompares;

  // Hand-computed symbol streams, first symbol in the top two bits.
  localparam logic [13:0] FRAME1 = 14'b11_10_00_01_01_11_00; // init 00, msg 10110
  localparam logic [13:0] FRAME2 = 14'b01_11_00_00_00_00_00; // init 11, msg 00000

  conv_encoder_tx #(
    .data_width(2),
    .seq_width (5),
    .G0        (3'b111),
    .G1        (3'b101)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .msg       (msg),
    .init_state(init_state),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .busy      (busy),
    .done      (done),
    .end_state (end_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [4:0] m, input logic [1:0] s);
    msg        = m;
    init_state = s;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Walks a 7-symbol frame already presenting its first symbol. stall_mask
  // bit i holds tx_ready low for 3 cycles on symbol i. With hammer set,
  // start stays high with a different msg/init_state throughout.
  task automatic run_frame(input string name, input logic [13:0] seq,
                           input logic [6:0] stall_mask, input bit hammer);
    logic [1:0] exp_sym;
    for (int i = 0; i < 7; i++) begin
      exp_sym = seq[13-2*i -: 2];
      if (hammer) begin
        start      = 1'b1;
        msg        = 5'b01001;
        init_state = 2'b01;
      end
      if (stall_mask[i]) begin
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk({name, "_stall_data"}, tx_data, exp_sym);
          chk({name, "_stall_valid"}, tx_valid, 1'b1);
          chk({name, "_stall_busy"}, busy, 1'b1);
        end
        tx_ready = 1'b1;
      end
      chk({name, "_valid"}, tx_valid, 1'b1);
      chk({name, "_data"}, tx_data, exp_sym);
      chk({name, "_last"}, tx_last, (i == 6));
      chk({name, "_busy"}, busy, 1'b1);
      chk({name, "_nodone"}, done, 1'b0);
      tick();
    end
  endtask

  task automatic check_done(input string name);
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_busy_off"}, busy, 1'b0);
    chk({name, "_valid_off"}, tx_valid, 1'b0);
    chk({name, "_last_off"}, tx_last, 1'b0);
    chk({name, "_end_state"}, end_state, 2'b00);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    msg         = '0;
    init_state  = '0;
    tx_ready    = 1'b1;
    tick();
    tick();
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 2'b00);
    chk("rst_last", tx_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_end_state", end_state, 2'b00);
    reset = 1'b0;
    tick();
    chk("idle_valid", tx_valid, 1'b0);

    // Frame 1: back-to-back symbols, full throughput.
    launch(5'b10110, 2'b00);
    run_frame("f1", FRAME1, 7'b0, 1'b0);
    check_done("f1");
    tick();
    chk("f1_done_pulse", done, 1'b0);

    // Frame 2: init 11, all-zero message.
    launch(5'b00000, 2'b11);
    run_frame("f2", FRAME2, 7'b0, 1'b0);
    check_done("f2");
    tick();

    // Backpressure on the 2nd and 6th symbols.
    launch(5'b10110, 2'b00);
    run_frame("bp", FRAME1, 7'b0100010, 1'b0);
    check_done("bp");
    tick();

    // start held with other data while busy; then start on the done cycle.
    launch(5'b10110, 2'b00);
    run_frame("hm", FRAME1, 7'b0, 1'b1);
    check_done("hm");
    msg        = 5'b10110;
    init_state = 2'b00;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    chk("b2b_valid_next", tx_valid, 1'b1);
    run_frame("b2b", FRAME1, 7'b0, 1'b0);
    check_done("b2b");
    tick();

    // Reset while the 3rd symbol is presented.
    launch(5'b10110, 2'b00);
    tick();
    tick();
    chk("mid_sym3", tx_data, 2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", tx_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_last", tx_last, 1'b0);
    tick();
    chk("mid_idle_valid", tx_valid, 1'b0);
    launch(5'b10110, 2'b00);
    run_frame("rf", FRAME1, 7'b0, 1'b0);
    check_done("rf");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_encoder_tx.md
Name: conv_encoder_tx

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder: the transmit end for the team's Viterbi decoder `top`.
- Accepts a parallel message word plus a starting trellis state, then serializes the message MSB first.
- Emits one 2-bit coded symbol per accepted handshake, then appends K-1=2 zero tail bits that flush the trellis.
- Drives the decoder's `rx_data` stream and produces bench stimulus for decoder regression.

Parameters:
- data_width, 2, coded symbol width (fixed at 2 for rate 1/2; other values unsupported)
- seq_width, 5, message bits per frame (legal range 2..32)
- G0, 3'b111, generator polynomial for tx_data[1], bit 2 = current input
- G1, 3'b101, generator polynomial for tx_data[0], bit 2 = current input

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  frame request, sampled only while busy=0
- msg  input  seq_width  message bits, transmitted MSB first, captured on accept
- init_state  input  data_width  starting encoder state {s1,s0}, captured on accept
- tx_ready  input  1  downstream accepts tx_data this cycle
- tx_valid  output  1  tx_data holds a valid coded symbol
- tx_data  output  data_width  coded symbol {G0 bit, G1 bit}
- tx_last  output  1  high with the final tail symbol
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the final symbol handshake
- end_state  output  data_width  encoder state after the last symbol (00 for a correct flush)

Behaviour:
- Reset (synchronous, active-high):
  - Next rising edge forces tx_valid, tx_data, tx_last, busy, done, end_state, the internal state register, the bit counter and the shift register to 0.
  - FSM returns to IDLE.
  - Reset mid-frame drops the frame; no partial-frame recovery.
- FSM states: IDLE, DATA, TAIL.
- Encoder math:
  - reg3 = {u, s1, s0}; tx_data[1] = ^(reg3 & G0); tx_data[0] = ^(reg3 & G1).
  - Next state = {u, s1}.
  - u is the current msg bit in DATA and 0 in TAIL.
- IDLE:
  - busy=0, tx_valid=0.
  - start=1 at an edge: capture msg into the shift register and init_state into the state register.
  - Same edge registers the first symbol (u = msg[seq_width-1]), sets tx_valid=1 and busy=1, counter=0, goes to DATA.
  - First symbol is valid one cycle after start.
- Handshake:
  - A symbol transfers on an edge where tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data and tx_last hold stable and nothing advances.
  - tx_valid never drops without a transfer, except on reset.
- DATA:
  - Each transfer updates the state, shifts the message left, increments the counter and registers the next symbol.
  - The transfer of bit seq_width-1 moves the FSM to TAIL with u=0.
- TAIL:
  - Two symbols; tx_last=1 with the second.
  - Frame length is always seq_width+2 symbols.
- Completion, on the tx_last transfer edge:
  - tx_valid=0, tx_last=0, busy=0, FSM to IDLE.
  - done=1 for exactly one cycle.
  - end_state latched (00 after a tail from any init_state).
- start while busy=1 is ignored, with no queuing.
- start in the cycle done=1 is accepted; minimum gap between a frame's last transfer and the next first symbol is 2 cycles.
- msg and init_state may change after the accept edge without effect.
- tx_ready held 1 gives a throughput of one symbol per cycle.

Test Plan:
- Reset, then init_state=00, msg=5'b10110, tx_ready=1, start pulse:
  - tx_data sequence 11,10,00,01,01,11,00 on 7 consecutive cycles.
  - tx_last only on the 7th symbol; done one cycle later; end_state=00.
- init_state=11, msg=5'b00000, tx_ready=1:
  - sequence 01,11,00,00,00,00,00; end_state=00.
  - Decoder `top` fed this with state=11 yields sequence=00000.
- Backpressure: frame 1 stimulus with tx_ready low for 3 cycles on the 2nd and 6th symbols:
  - tx_data stays 10 and 11 respectively while stalled.
  - Same 7-symbol sequence results; busy stays 1 throughout.
- start asserted repeatedly while busy with different msg:
  - Frame output unchanged.
  - start on the done cycle launches a new frame whose first symbol is valid the next cycle.
- reset asserted during the 3rd symbol:
  - Next edge gives tx_valid=0, busy=0, done=0.
  - A fresh start then reproduces the full frame-1 sequence.
